// File: rtl/game_pkg.sv
// Shared types for the number-guessing game: FSM states, hint codes, default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    HINT_NONE = 2'b00,
    HINT_LOW  = 2'b01,
    HINT_HIGH = 2'b10,
    HINT_OK   = 2'b11
  } hint_t;

endpackage

// File: rtl/guess_checker_if.sv
// Bundle between guess_checker and its environment: RNG request/response, guess input, status.
// Latency: n/a (wires only).
// Backpressure: guess transfer = guess_valid & guess_ready; RNG uses generate_num/generated.
//   slave  : the guess_checker side
//   master : the environment (random_gen + input/display logic)
interface guess_checker_if
  import game_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_TRIES = 7
);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic             start;
  logic             generate_num;
  logic [WIDTH-1:0] rand_num;
  logic             generated;
  logic             guess_valid;
  logic [WIDTH-1:0] guess;
  logic             guess_ready;
  logic [1:0]       hint;
  logic             hint_valid;
  logic [TRY_W-1:0] tries;
  logic             win;
  logic             lose;
  logic [WIDTH-1:0] secret_out;
  logic             busy;

  modport slave (
    input  start, rand_num, generated, guess_valid, guess,
    output generate_num, guess_ready, hint, hint_valid, tries, win, lose, secret_out, busy
  );

  modport master (
    output start, rand_num, generated, guess_valid, guess,
    input  generate_num, guess_ready, hint, hint_valid, tries, win, lose, secret_out, busy
  );

endinterface

// File: rtl/guess_checker.sv
// Requests a secret from random_gen, then scores up to MAX_TRIES guesses (low/high/correct, win/lose).
// Latency: hint/hint_valid/tries update 1 cycle after an accepted guess; secret captured the cycle generated is seen.
// Backpressure: guess_ready high only in PLAY, one guess per cycle; REQ waits indefinitely for generated.
//   Ports: clk, reset_n (async active-low), bus (guess_checker_if.slave):
//   start/generate_num/rand_num/generated, guess_valid/guess/guess_ready,
//   hint/hint_valid/tries/win/lose/secret_out/busy.
module guess_checker
  import game_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_TRIES = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  guess_checker_if.slave  bus
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_ONE  = TRY_W'(1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] secret_q, secret_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;
  hint_t            hint_q, hint_d;
  logic             hint_vld_q, hint_vld_d;

  logic             xfer;
  logic [TRY_W-1:0] tries_inc;

  assign xfer      = bus.guess_valid && (state_q == PLAY);
  assign tries_inc = tries_q + TRY_ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      secret_q   <= '0;
      tries_q    <= '0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      hint_q     <= HINT_NONE;
      hint_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      secret_q   <= secret_d;
      tries_q    <= tries_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
      hint_q     <= hint_d;
      hint_vld_q <= hint_vld_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    secret_d   = secret_q;
    tries_d    = tries_q;
    win_d      = win_q;
    lose_d     = lose_q;
    hint_d     = hint_q;
    hint_vld_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          tries_d = '0;
          win_d   = 1'b0;
          lose_d  = 1'b0;
          hint_d  = HINT_NONE;
          state_d = REQ;
        end
      end
      REQ: begin
        // generated is sticky, so an un-reset RNG makes this a single-cycle REQ.
        if (bus.generated) begin
          secret_d = bus.rand_num;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        if (xfer) begin
          tries_d    = tries_inc;
          hint_vld_d = 1'b1;
          if (bus.guess == secret_q) begin
            hint_d  = HINT_OK;
            win_d   = 1'b1;
            state_d = DONE;
          end else begin
            hint_d = (bus.guess < secret_q) ? HINT_LOW : HINT_HIGH;
            // Out of tries on a wrong guess; win takes priority above so both never set.
            if (tries_inc == TRY_LAST) begin
              lose_d  = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.generate_num = (state_q == REQ);
  assign bus.guess_ready  = (state_q == PLAY);
  assign bus.busy         = (state_q == REQ) || (state_q == PLAY);
  assign bus.hint         = hint_q;
  assign bus.hint_valid   = hint_vld_q;
  assign bus.tries        = tries_q;
  assign bus.win          = win_q;
  assign bus.lose         = lose_q;
  assign bus.secret_out   = (state_q == DONE) ? secret_q : '0;

endmodule
